irrigation_zone_sched: RTL

Parametrised multi-zone irrigation scheduler for the water-control datapath. It accepts per-valve watering requests from N zones and grants zones round-robin, capped at a maximum number of concurrently open zones. Each granted zone runs for a programmed duration, and watering is gated by the tank-level check. Any low-water or sensor fault latches an error state that closes every valve until the fault is explicitly cleared.

---
 rtl/irrigation_zone_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/irrigation_zone_sched.sv
// rtl/irrigation_zone_sched.sv - round-robin multi-zone irrigation scheduler with tank-level gating and latched fault state
module irrigation_zone_sched #(
    parameter int N_ZONES  = 4,
    parameter int VPZ      = 2,
    parameter int DUR_W    = 8,
    parameter int MAX_ON   = 2,
    parameter int LVL_W    = 4,
    parameter int LVL_MIN  = 3,
    parameter int LVL_CRIT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_ZONES*VPZ-1:0]   req,
    input  logic [DUR_W-1:0]         dur,
    input  logic [LVL_W-1:0]         level,
    input  logic                     sensor_fault,
    input  logic                     err_clr,
    output logic [N_ZONES*VPZ-1:0]   valve,
    output logic [N_ZONES-1:0]       zone_busy,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int PTR_W = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int CNT_W = $clog2(N_ZONES + 1);

    typedef enum logic {G_RUN = 1'b0, G_FAULT = 1'b1} g_state_t;
    typedef enum logic {Z_IDLE = 1'b0, Z_WATER = 1'b1} z_state_t;

    g_state_t               gst_q, gst_d;
    z_state_t               zst_q  [N_ZONES];
    z_state_t               zst_d  [N_ZONES];
    logic [DUR_W-1:0]       cnt_q  [N_ZONES];
    logic [DUR_W-1:0]       cnt_d  [N_ZONES];
    logic [VPZ-1:0]         mask_q [N_ZONES];
    logic [VPZ-1:0]         mask_d [N_ZONES];
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [N_ZONES*VPZ-1:0] valve_q, valve_d;
    logic [N_ZONES-1:0]     zone_busy_q, zone_busy_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;

    logic                   lvl_crit_low, lvl_ok, fault_now, grant_ok, found;
    logic [N_ZONES-1:0]     pending;
    logic [CNT_W-1:0]       n_water;
    logic [PTR_W-1:0]       cand, gnt;

    always_comb begin
        lvl_crit_low = level < LVL_W'(LVL_CRIT);
        lvl_ok       = level >= LVL_W'(LVL_MIN);
        fault_now    = lvl_crit_low | sensor_fault;
        n_water      = '0;
        pending      = '0;
        found        = 1'b0;
        cand         = '0;
        gnt          = '0;
        gst_d        = gst_q;
        rr_d         = rr_q;
        err_code_d   = err_code_q;
        for (int z = 0; z < N_ZONES; z++) begin
            zst_d[z]   = zst_q[z];
            cnt_d[z]   = cnt_q[z];
            mask_d[z]  = mask_q[z];
            pending[z] = (zst_q[z] == Z_IDLE) && (|req[z*VPZ +: VPZ]);
            if (zst_q[z] == Z_WATER) begin
                n_water = n_water + CNT_W'(1);
            end
        end

        // Slot count uses current state, so a finishing zone still holds its slot this cycle.
        grant_ok = (gst_q == G_RUN) && !fault_now && lvl_ok && (n_water < CNT_W'(MAX_ON));
        for (int i = 0; i < N_ZONES; i++) begin
            cand = PTR_W'((int'(rr_q) + i) % N_ZONES);
            if (!found && pending[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end

        if (gst_q == G_RUN) begin
            for (int z = 0; z < N_ZONES; z++) begin
                if (zst_q[z] == Z_WATER) begin
                    cnt_d[z] = cnt_q[z] - DUR_W'(1);
                    if (cnt_q[z] == DUR_W'(1)) begin
                        zst_d[z]  = Z_IDLE;
                        mask_d[z] = '0;
                    end
                end
            end
            if (grant_ok && found) begin
                zst_d[gnt]  = Z_WATER;
                mask_d[gnt] = req[gnt*VPZ +: VPZ];
                cnt_d[gnt]  = (dur == '0) ? DUR_W'(1) : dur;
                rr_d        = (gnt == PTR_W'(N_ZONES - 1)) ? '0 : gnt + PTR_W'(1);
            end
            // Fault overrides everything above, including a grant in the same cycle.
            if (fault_now) begin
                gst_d      = G_FAULT;
                err_code_d = {sensor_fault, lvl_crit_low};
                for (int z = 0; z < N_ZONES; z++) begin
                    zst_d[z]  = Z_IDLE;
                    cnt_d[z]  = '0;
                    mask_d[z] = '0;
                end
            end
        end else if (err_clr && !lvl_crit_low && !sensor_fault) begin
            gst_d      = G_RUN;
            err_code_d = 2'b00;
        end

        for (int z = 0; z < N_ZONES; z++) begin
            valve_d[z*VPZ +: VPZ] = (zst_d[z] == Z_WATER) ? mask_d[z] : '0;
            zone_busy_d[z]        = (zst_d[z] == Z_WATER);
        end
        err_d = (gst_d == G_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gst_q       <= G_RUN;
            rr_q        <= '0;
            valve_q     <= '0;
            zone_busy_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            for (int z = 0; z < N_ZONES; z++) begin
                zst_q[z]  <= Z_IDLE;
                cnt_q[z]  <= '0;
                mask_q[z] <= '0;
            end
        end else begin
            gst_q       <= gst_d;
            rr_q        <= rr_d;
            valve_q     <= valve_d;
            zone_busy_q <= zone_busy_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            for (int z = 0; z < N_ZONES; z++) begin
                zst_q[z]  <= zst_d[z];
                cnt_q[z]  <= cnt_d[z];
                mask_q[z] <= mask_d[z];
            end
        end
    end

    assign valve     = valve_q;
    assign zone_busy = zone_busy_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
